// File: rtl/regfile_mp_sb_if.sv
// Decode/writeback bus of the register file: read ports, two write ports,
// reservations and the clear sweep control.
interface regfile_mp_sb_if #(
  parameter int unsigned n         = 16,
  parameter int unsigned addr_size = 3,
  parameter int unsigned RD_PORTS  = 2
);
  logic [RD_PORTS*addr_size-1:0] Rs;
  logic [RD_PORTS*n-1:0]         Rd;
  logic [RD_PORTS-1:0]           RdPending;
  logic                          WE0;
  logic [addr_size-1:0]          Rw0;
  logic [n-1:0]                  WData0;
  logic                          WE1;
  logic [addr_size-1:0]          Rw1;
  logic [n-1:0]                  WData1;
  logic                          Reserve;
  logic [addr_size-1:0]          RwRes;
  logic                          Clear;
  logic                          Busy;

  modport master (
    output Rs, WE0, Rw0, WData0, WE1, Rw1, WData1, Reserve, RwRes, Clear,
    input  Rd, RdPending, Busy
  );

  modport slave (
    input  Rs, WE0, Rw0, WData0, WE1, Rw1, WData1, Reserve, RwRes, Clear,
    output Rd, RdPending, Busy
  );
endinterface

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with two prioritised write ports, optional
// write-to-read bypass, a pending-write scoreboard and a sequenced clear sweep.
module regfile_mp_sb #(
  parameter int unsigned n         = 16,
  parameter int unsigned reg_count = 8,
  parameter int unsigned addr_size = 3,
  parameter int unsigned RD_PORTS  = 2,
  parameter int unsigned BYPASS    = 1,
  parameter int unsigned ZERO_REG  = 0
) (
  input logic            Clock,
  input logic            Reset,
  regfile_mp_sb_if.slave bus
);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t               state;
  logic [addr_size-1:0] idx;
  logic                 busy;
  logic [n-1:0]         regs [reg_count];
  logic [reg_count-1:0] pending;

  logic                 w0_ok;
  logic                 w1_ok;
  logic                 res_ok;
  logic [RD_PORTS*n-1:0] rd_c;
  logic [RD_PORTS-1:0]  rd_pend_c;
  logic [addr_size-1:0] rd_addr;
  logic [n-1:0]         rd_word;
  logic                 rd_pend;

  // Address maps onto a real, writable entry (register 0 is hardwired when ZERO_REG).
  function automatic logic writable(input logic [addr_size-1:0] a);
    return (32'(a) < reg_count) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  always_comb begin
    w0_ok  = (state == IDLE) && bus.WE0     && writable(bus.Rw0);
    w1_ok  = (state == IDLE) && bus.WE1     && writable(bus.Rw1);
    res_ok = (state == IDLE) && bus.Reserve && writable(bus.RwRes);
  end

  // Storage, scoreboard and clear sequencer share one register process.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= IDLE;
      idx     <= '0;
      busy    <= 1'b0;
      pending <= '0;
      for (int unsigned i = 0; i < reg_count; i++) regs[i] <= '0;
    end else if (state == SWEEP) begin
      for (int unsigned i = 0; i < reg_count; i++) begin
        if (idx == addr_size'(i)) begin
          regs[i]    <= '0;
          pending[i] <= 1'b0;
        end
      end
      if (idx == addr_size'(reg_count - 1)) begin
        state <= IDLE;
        busy  <= 1'b0;
        idx   <= '0;
      end else begin
        idx <= idx + addr_size'(1);
      end
    end else begin
      for (int unsigned i = 0; i < reg_count; i++) begin
        if (w1_ok && (bus.Rw1 == addr_size'(i)))      regs[i] <= bus.WData1;
        else if (w0_ok && (bus.Rw0 == addr_size'(i))) regs[i] <= bus.WData0;
        // A same-cycle reservation is the newer producer, so it beats the write clear.
        if (res_ok && (bus.RwRes == addr_size'(i)))
          pending[i] <= 1'b1;
        else if ((w1_ok && (bus.Rw1 == addr_size'(i))) || (w0_ok && (bus.Rw0 == addr_size'(i))))
          pending[i] <= 1'b0;
      end
      if (bus.Clear) begin
        state <= SWEEP;
        idx   <= '0;
        busy  <= 1'b1;
      end
    end
  end

  always_comb begin
    rd_c      = '0;
    rd_pend_c = '0;
    rd_addr   = '0;
    rd_word   = '0;
    rd_pend   = 1'b0;
    for (int unsigned k = 0; k < RD_PORTS; k++) begin
      rd_addr = bus.Rs[k*addr_size +: addr_size];
      rd_word = '0;
      rd_pend = 1'b0;
      for (int unsigned i = 0; i < reg_count; i++) begin
        if (rd_addr == addr_size'(i)) begin
          rd_word = regs[i];
          rd_pend = pending[i];
        end
      end
      if (BYPASS != 0) begin
        if (w1_ok && (bus.Rw1 == rd_addr)) begin
          rd_word = bus.WData1;
          rd_pend = 1'b0;
        end else if (w0_ok && (bus.Rw0 == rd_addr)) begin
          rd_word = bus.WData0;
          rd_pend = 1'b0;
        end
      end
      rd_c[k*n +: n] = rd_word;
      rd_pend_c[k]   = rd_pend;
    end
  end

  assign bus.Rd        = rd_c;
  assign bus.RdPending = rd_pend_c;
  assign bus.Busy      = busy;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Scoreboard bench: DUT A (bypass, no zero reg) and DUT B (no bypass, zero reg)
// run on identical stimulus against a behavioural model of both variants.
module tb_regfile_mp_sb;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic [2:0] rs0 = '0, rs1 = '0, rw0 = '0, rw1 = '0, rwres = '0;
  logic       we0 = 1'b0, we1 = 1'b0, reserve = 1'b0, clear = 1'b0;
  logic [15:0] wd0 = '0, wd1 = '0;

  always #5 Clock = ~Clock;

  regfile_mp_sb_if #(.n(16), .addr_size(3), .RD_PORTS(2)) bus_a ();
  regfile_mp_sb_if #(.n(16), .addr_size(3), .RD_PORTS(2)) bus_b ();

  assign bus_a.Rs = {rs1, rs0};  assign bus_b.Rs = {rs1, rs0};
  assign bus_a.WE0 = we0;        assign bus_b.WE0 = we0;
  assign bus_a.Rw0 = rw0;        assign bus_b.Rw0 = rw0;
  assign bus_a.WData0 = wd0;     assign bus_b.WData0 = wd0;
  assign bus_a.WE1 = we1;        assign bus_b.WE1 = we1;
  assign bus_a.Rw1 = rw1;        assign bus_b.Rw1 = rw1;
  assign bus_a.WData1 = wd1;     assign bus_b.WData1 = wd1;
  assign bus_a.Reserve = reserve; assign bus_b.Reserve = reserve;
  assign bus_a.RwRes = rwres;    assign bus_b.RwRes = rwres;
  assign bus_a.Clear = clear;    assign bus_b.Clear = clear;

  regfile_mp_sb #(.n(16), .reg_count(8), .addr_size(3), .RD_PORTS(2), .BYPASS(1), .ZERO_REG(0))
    dut_a (.Clock(Clock), .Reset(Reset), .bus(bus_a.slave));
  regfile_mp_sb #(.n(16), .reg_count(8), .addr_size(3), .RD_PORTS(2), .BYPASS(0), .ZERO_REG(1))
    dut_b (.Clock(Clock), .Reset(Reset), .bus(bus_b.slave));

  // Model: variant 0 = DUT A, variant 1 = DUT B.
  logic [15:0] m [2][8];
  logic        p [2][8];
  logic        msweep = 1'b0;
  int          midx = 0;
  int          total = 0;
  int          bad = 0;

  typedef struct {
    string       tag;
    int          v;
    int          port;
    logic [15:0] data;
    logic        pend;
  } exp_t;
  exp_t q[$];

  function automatic logic bypass_hit(int v, logic [2:0] a);
    return (v == 0) && !msweep && ((we1 && rw1 == a) || (we0 && rw0 == a));
  endfunction

  function automatic logic [15:0] exp_data(int v, logic [2:0] a);
    if (v == 1 && a == 3'd0) return 16'h0000;
    if (v == 0 && !msweep) begin
      if (we1 && rw1 == a) return wd1;
      if (we0 && rw0 == a) return wd0;
    end
    return m[v][a];
  endfunction

  function automatic logic exp_pend(int v, logic [2:0] a);
    if (v == 1 && a == 3'd0) return 1'b0;
    if (bypass_hit(v, a)) return 1'b0;
    return p[v][a];
  endfunction

  task automatic model_edge();
    if (Reset) begin
      for (int v = 0; v < 2; v++)
        for (int i = 0; i < 8; i++) begin m[v][i] = '0; p[v][i] = 1'b0; end
      msweep = 1'b0;
      midx   = 0;
    end else if (msweep) begin
      for (int v = 0; v < 2; v++) begin m[v][midx] = '0; p[v][midx] = 1'b0; end
      if (midx == 7) msweep = 1'b0;
      else midx++;
    end else begin
      for (int v = 0; v < 2; v++) begin
        if (we0 && !(v == 1 && rw0 == 3'd0)) begin m[v][rw0] = wd0; p[v][rw0] = 1'b0; end
        if (we1 && !(v == 1 && rw1 == 3'd0)) begin m[v][rw1] = wd1; p[v][rw1] = 1'b0; end
        if (reserve && !(v == 1 && rwres == 3'd0)) p[v][rwres] = 1'b1;
      end
      if (clear) begin msweep = 1'b1; midx = 0; end
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    we0 = 1'b0; we1 = 1'b0; reserve = 1'b0; clear = 1'b0;
  endtask

  task automatic push_reads(string tag);
    exp_t e;
    for (int v = 0; v < 2; v++)
      for (int k = 0; k < 2; k++) begin
        e.tag  = tag;
        e.v    = v;
        e.port = k;
        e.data = exp_data(v, (k == 1) ? rs1 : rs0);
        e.pend = exp_pend(v, (k == 1) ? rs1 : rs0);
        q.push_back(e);
      end
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] rdv;
    logic [1:0]  pv;
    logic [15:0] got;
    while (q.size() > 0) begin
      e   = q.pop_front();
      rdv = (e.v == 1) ? bus_b.Rd : bus_a.Rd;
      pv  = (e.v == 1) ? bus_b.RdPending : bus_a.RdPending;
      got = (e.port == 1) ? rdv[31:16] : rdv[15:0];
      total++;
      if (got !== e.data) begin
        bad++;
        $display("FAIL %s dut%0d port%0d Rd got=%h want=%h", e.tag, e.v, e.port, got, e.data);
      end
      total++;
      if (pv[e.port] !== e.pend) begin
        bad++;
        $display("FAIL %s dut%0d port%0d RdPending got=%b want=%b", e.tag, e.v, e.port, pv[e.port], e.pend);
      end
    end
  endtask

  task automatic step_read(string tag);
    push_reads(tag);
    #1;
    drain();
  endtask

  task automatic check_busy(string tag);
    total++;
    if ({bus_a.Busy, bus_b.Busy} !== {2{msweep}}) begin
      bad++;
      $display("FAIL %s Busy got=%b%b want=%b", tag, bus_a.Busy, bus_b.Busy, msweep);
    end
  endtask

  task automatic read_all(string tag);
    for (int a = 0; a < 8; a++) begin
      rs0 = 3'(a);
      rs1 = 3'(7 - a);
      step_read(tag);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check_busy("reset_busy");
    read_all("reset_read");
  endtask

  task automatic test_bypass();
    we0 = 1'b1; rw0 = 3'd3; wd0 = 16'h1234; rs0 = 3'd3; rs1 = 3'd4;
    step_read("bypass_same");
    tick();
    idle_inputs();
    step_read("bypass_after");
  endtask

  task automatic test_collision();
    we0 = 1'b1; rw0 = 3'd5; wd0 = 16'hAAAA;
    we1 = 1'b1; rw1 = 3'd5; wd1 = 16'h5555;
    rs0 = 3'd5; rs1 = 3'd5;
    step_read("collide_same");
    tick();
    idle_inputs();
    step_read("collide_after");
  endtask

  task automatic test_scoreboard();
    rs0 = 3'd2; rs1 = 3'd3;
    reserve = 1'b1; rwres = 3'd2;
    step_read("sb_reserve_same");
    tick();
    idle_inputs();
    step_read("sb_reserved");
    reserve = 1'b1; rwres = 3'd2;
    tick();
    idle_inputs();
    step_read("sb_rereserve");
    we0 = 1'b1; rw0 = 3'd2; wd0 = 16'h00FF;
    step_read("sb_write_bypass");
    tick();
    idle_inputs();
    step_read("sb_cleared");
    we1 = 1'b1; rw1 = 3'd2; wd1 = 16'h0F0F; reserve = 1'b1; rwres = 3'd2;
    tick();
    idle_inputs();
    step_read("sb_write_and_reserve");
  endtask

  task automatic test_zero_reg();
    we1 = 1'b1; rw1 = 3'd0; wd1 = 16'hFFFF; reserve = 1'b1; rwres = 3'd0;
    rs0 = 3'd0; rs1 = 3'd2;
    step_read("zero_same");
    tick();
    idle_inputs();
    step_read("zero_after");
  endtask

  task automatic test_sweep();
    int cnt;
    for (int i = 0; i < 8; i++) begin
      we0 = 1'b1; rw0 = 3'(i); wd0 = 16'(16'h0101 * (i + 1));
      tick();
    end
    idle_inputs();
    reserve = 1'b1; rwres = 3'd6;
    tick();
    idle_inputs();
    read_all("fill");
    clear = 1'b1;
    tick();
    check_busy("sweep_start");
    cnt = 0;
    for (int c = 0; c < 20 && bus_a.Busy; c++) begin
      we1 = 1'b1; rw1 = 3'(c % 8); wd1 = 16'hBEEF;
      reserve = 1'b1; rwres = 3'((c + 3) % 8);
      clear = 1'b1;
      rs0 = 3'(c % 8); rs1 = 3'((c + 1) % 8);
      step_read("sweep_mid");
      tick();
      cnt++;
      check_busy("sweep_busy");
    end
    idle_inputs();
    total++;
    if (cnt !== 8) begin
      bad++;
      $display("FAIL sweep_len busy_cycles got=%0d want=8", cnt);
    end
    read_all("sweep_done");
  endtask

  task automatic test_clear_with_write();
    we0 = 1'b1; rw0 = 3'd4; wd0 = 16'h4444; clear = 1'b1;
    tick();
    idle_inputs();
    check_busy("cw_busy");
    rs0 = 3'd4; rs1 = 3'd0;
    step_read("cw_visible");
    for (int c = 0; c < 20 && bus_a.Busy; c++) tick();
    check_busy("cw_end");
    step_read("cw_zeroed");
  endtask

  task automatic test_reset_mid_sweep();
    we0 = 1'b1; rw0 = 3'd7; wd0 = 16'h1111; reserve = 1'b1; rwres = 3'd5;
    tick();
    idle_inputs();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int c = 0; c < 3; c++) tick();
    check_busy("rms_before");
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check_busy("rms_busy");
    read_all("rms_read");
  endtask

  initial begin
    for (int v = 0; v < 2; v++)
      for (int i = 0; i < 8; i++) begin m[v][i] = '0; p[v][i] = 1'b0; end
    test_reset();
    test_bypass();
    test_collision();
    test_scoreboard();
    test_zero_reg();
    test_sweep();
    test_clear_with_write();
    test_reset_mid_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
